// File: rtl/ssd1306_spi_sink.sv
// Panel-side model of the SSD1306 4-wire SPI link: synchronises and deserialises the
// serial stream, decodes the command subset into panel state and turns data bytes into framebuffer writes.
module ssd1306_spi_sink #(
  parameter int FB_DEPTH = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_sclk,
  input  logic       io_sdin,
  input  logic       io_cs,
  input  logic       io_dc,
  input  logic       io_reset,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       rx_abort,
  output logic       display_on,
  output logic       invert,
  output logic [7:0] contrast,
  output logic [5:0] mux_ratio,
  output logic       charge_pump,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARG1 = 2'd1;
  localparam logic [1:0] ARG2 = 2'd2;
  localparam logic [9:0] FB_LAST = 10'(FB_DEPTH - 1);

  logic       sclk_q1_r, sclk_q2_r, sclk_q3_r;
  logic       sdin_q1_r, sdin_q2_r;
  logic       cs_q1_r, cs_q2_r, cs_q3_r;
  logic       dc_q1_r, dc_q2_r;
  logic       prst_q1_r, prst_q2_r;
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic [1:0] state_r;
  logic [7:0] opcode_r;
  logic [9:0] ptr_r;

  logic       clr_s;
  logic       sclk_rise_s;
  logic       cs_rise_s;
  logic       shift_en_s;

  // Input synchronisers; only rst_n clears them so a held panel reset stays visible
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q1_r <= 1'b0;
      sclk_q2_r <= 1'b0;
      sclk_q3_r <= 1'b0;
      sdin_q1_r <= 1'b0;
      sdin_q2_r <= 1'b0;
      cs_q1_r   <= 1'b1;
      cs_q2_r   <= 1'b1;
      cs_q3_r   <= 1'b1;
      dc_q1_r   <= 1'b0;
      dc_q2_r   <= 1'b0;
      prst_q1_r <= 1'b1;
      prst_q2_r <= 1'b1;
    end else begin
      sclk_q1_r <= io_sclk;
      sclk_q2_r <= sclk_q1_r;
      sclk_q3_r <= sclk_q2_r;
      sdin_q1_r <= io_sdin;
      sdin_q2_r <= sdin_q1_r;
      cs_q1_r   <= io_cs;
      cs_q2_r   <= cs_q1_r;
      cs_q3_r   <= cs_q2_r;
      dc_q1_r   <= io_dc;
      dc_q2_r   <= dc_q1_r;
      prst_q1_r <= io_reset;
      prst_q2_r <= prst_q1_r;
    end
  end

  // A CS rise landing on the 8th SCLK rise still completes the byte
  always_comb begin
    clr_s       = !rst_n || !prst_q2_r;
    sclk_rise_s = sclk_q2_r && !sclk_q3_r;
    cs_rise_s   = cs_q2_r && !cs_q3_r;
    shift_en_s  = sclk_rise_s && (!cs_q2_r || (cs_rise_s && (bit_cnt_r == 3'd7)));
  end

  // Deserialiser: MSB-first shift, byte completion and mid-byte abort
  always_ff @(posedge clk) begin
    if (clr_s) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      rx_valid  <= 1'b0;
      rx_abort  <= 1'b0;
      rx_byte   <= 8'h00;
      rx_dc     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
      if (shift_en_s) begin
        shift_r <= {shift_r[6:0], sdin_q2_r};
        if (bit_cnt_r == 3'd7) begin
          rx_valid  <= 1'b1;
          rx_byte   <= {shift_r[6:0], sdin_q2_r};
          rx_dc     <= dc_q2_r;
          bit_cnt_r <= 3'd0;
        end else begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
      end else if (cs_q2_r && (bit_cnt_r != 3'd0)) begin
        rx_abort  <= 1'b1;
        bit_cnt_r <= 3'd0;
        shift_r   <= 8'h00;
      end
    end
  end

  // Command decoder FSM and framebuffer write pointer
  always_ff @(posedge clk) begin
    if (clr_s) begin
      state_r     <= IDLE;
      opcode_r    <= 8'h00;
      ptr_r       <= 10'd0;
      display_on  <= 1'b0;
      invert      <= 1'b0;
      contrast    <= 8'h7F;
      mux_ratio   <= 6'h3F;
      charge_pump <= 1'b0;
      fb_we       <= 1'b0;
      fb_addr     <= 10'd0;
      fb_wdata    <= 8'h00;
    end else begin
      fb_we <= 1'b0;
      if (rx_valid) begin
        if (rx_dc) begin
          // Data aborts any pending argument and is still written
          fb_we    <= 1'b1;
          fb_wdata <= rx_byte;
          fb_addr  <= ptr_r;
          ptr_r    <= (ptr_r == FB_LAST) ? 10'd0 : ptr_r + 10'd1;
          state_r  <= IDLE;
        end else begin
          case (state_r)
            IDLE: begin
              case (rx_byte)
                8'hAE: display_on <= 1'b0;
                8'hAF: display_on <= 1'b1;
                8'hA6: invert <= 1'b0;
                8'hA7: invert <= 1'b1;
                8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D, 8'h21, 8'h22: begin
                  opcode_r <= rx_byte;
                  state_r  <= ARG1;
                end
                default: state_r <= IDLE;
              endcase
            end
            ARG1: begin
              case (opcode_r)
                8'h81: contrast <= rx_byte;
                8'hA8: mux_ratio <= rx_byte[5:0];
                8'h8D: charge_pump <= rx_byte[2];
                8'h21: ptr_r[6:0] <= rx_byte[6:0];
                8'h22: ptr_r[9:7] <= rx_byte[2:0];
                default: opcode_r <= opcode_r;
              endcase
              state_r <= ((opcode_r == 8'h21) || (opcode_r == 8'h22)) ? ARG2 : IDLE;
            end
            ARG2:    state_r <= IDLE;
            default: state_r <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Directed bench for ssd1306_spi_sink: SPI master tasks, a negedge monitor
// counting pulses, and a table of command/data bytes with expected panel state.
module tb_ssd1306_spi_sink;

  logic       clk = 1'b0;
  logic       rst_n, io_sclk, io_sdin, io_cs, io_dc, io_reset;
  logic       rx_valid, rx_dc, rx_abort, display_on, invert, charge_pump, fb_we;
  logic [7:0] rx_byte, contrast, fb_wdata;
  logic [5:0] mux_ratio;
  logic [9:0] fb_addr;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int abort_cnt = 0;
  int we_cnt = 0;
  int bulk_bad = 0;
  int bulk_idx = 0;
  bit bulk_mode = 1'b0;
  logic [7:0] last_rx_byte = 8'h00;
  logic [9:0] last_addr = 10'd0;
  logic [7:0] last_data = 8'h00;

  typedef struct {
    logic [7:0] b;
    logic       d;
    logic       disp;
    logic       inv;
    logic [7:0] con;
    int         we_inc;
  } vec_t;

  vec_t tbl [10];
  logic [7:0] startup [23];

  ssd1306_spi_sink #(.FB_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs),
    .io_dc(io_dc), .io_reset(io_reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_dc(rx_dc), .rx_abort(rx_abort), .display_on(display_on), .invert(invert),
    .contrast(contrast), .mux_ratio(mux_ratio), .charge_pump(charge_pump),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata)
  );

  always #5 clk = ~clk;

  // Monitor on the inactive edge
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_rx_byte = rx_byte;
    end
    if (rx_abort) abort_cnt++;
    if (fb_we) begin
      we_cnt++;
      last_addr = fb_addr;
      last_data = fb_wdata;
      if (bulk_mode) begin
        if (fb_addr !== 10'(bulk_idx % 1024) || fb_wdata !== 8'h57) bulk_bad++;
        bulk_idx++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input logic d, input int ph);
    for (int i = 7; i > 7 - n; i--) begin
      io_sdin = b[i];
      io_dc   = d;
      wait_clk(ph);
      io_sclk = 1'b1;
      wait_clk(ph);
      io_sclk = 1'b0;
    end
  endtask

  initial begin
    int we0, v0;
    startup = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                8'h40, 8'hA1, 8'hC8, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'h8D, 8'h14, 8'hA4, 8'hAF};
    tbl[0] = '{8'hAE, 1'b0, 1'b0, 1'b0, 8'h7F, 0};
    tbl[1] = '{8'hAF, 1'b0, 1'b1, 1'b0, 8'h7F, 0};
    tbl[2] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'h7F, 0};
    tbl[3] = '{8'h10, 1'b0, 1'b1, 1'b0, 8'h10, 0};
    tbl[4] = '{8'hA7, 1'b0, 1'b1, 1'b1, 8'h10, 0};
    tbl[5] = '{8'hA6, 1'b0, 1'b1, 1'b0, 8'h10, 0};
    tbl[6] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'h10, 0};
    tbl[7] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'h10, 1};
    tbl[8] = '{8'h20, 1'b0, 1'b1, 1'b0, 8'h10, 0};
    tbl[9] = '{8'hA7, 1'b0, 1'b1, 1'b0, 8'h10, 0};

    rst_n = 1'b0; io_sclk = 1'b0; io_sdin = 1'b0; io_cs = 1'b1; io_dc = 1'b0; io_reset = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(3);
    chk("rst_display_on", display_on, 1'b0);
    chk("rst_invert", invert, 1'b0);
    chk("rst_contrast", contrast, 8'h7F);
    chk("rst_mux_ratio", mux_ratio, 6'h3F);
    chk("rst_charge_pump", charge_pump, 1'b0);
    chk("rst_fb_addr", fb_addr, 10'd0);
    chk("rst_fb_wdata", fb_wdata, 8'h00);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_pulses", {rx_valid, rx_abort, fb_we, rx_dc}, 4'b0000);

    // Startup command stream
    io_cs = 1'b0;
    for (int i = 0; i < 23; i++) spi_bits(startup[i], 8, 1'b0, 4);
    wait_clk(8);
    io_cs = 1'b1;
    wait_clk(8);
    chk("startup_rx_valid", valid_cnt, 23);
    chk("startup_display_on", display_on, 1'b1);
    chk("startup_contrast", contrast, 8'h7F);
    chk("startup_charge_pump", charge_pump, 1'b1);
    chk("startup_mux_ratio", mux_ratio, 6'h3F);
    chk("startup_no_write", we_cnt, 0);

    // Fill past the end of the framebuffer to see the wrap
    bulk_mode = 1'b1;
    io_cs = 1'b0;
    for (int i = 0; i < 1026; i++) spi_bits(8'h57, 8, 1'b1, 2);
    wait_clk(8);
    io_cs = 1'b1;
    bulk_mode = 1'b0;
    chk("bulk_we_count", we_cnt, 1026);
    chk("bulk_bad_writes", bulk_bad, 0);
    chk("bulk_last_addr", last_addr, 10'd1);

    // Table: byte applied, then panel state compared
    io_cs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      we0 = we_cnt;
      spi_bits(tbl[i].b, 8, tbl[i].d, 3);
      wait_clk(8);
      chk($sformatf("tbl%0d_display_on", i), display_on, tbl[i].disp);
      chk($sformatf("tbl%0d_invert", i), invert, tbl[i].inv);
      chk($sformatf("tbl%0d_contrast", i), contrast, tbl[i].con);
      chk($sformatf("tbl%0d_we", i), we_cnt - we0, tbl[i].we_inc);
      if (i == 7) begin
        chk("tbl_data_wdata", last_data, 8'hFF);
        chk("tbl_data_addr", last_addr, 10'd2);
      end
    end

    // Column/page addressing, second arguments ignored
    we0 = we_cnt;
    spi_bits(8'h21, 8, 1'b0, 3); spi_bits(8'h05, 8, 1'b0, 3); spi_bits(8'h7F, 8, 1'b0, 3);
    spi_bits(8'h22, 8, 1'b0, 3); spi_bits(8'h02, 8, 1'b0, 3); spi_bits(8'h07, 8, 1'b0, 3);
    spi_bits(8'hAA, 8, 1'b1, 3);
    wait_clk(8);
    io_cs = 1'b1;
    wait_clk(8);
    chk("addr_we", we_cnt - we0, 1);
    chk("addr_fb_addr", last_addr, 10'h105);
    chk("addr_fb_wdata", last_data, 8'hAA);

    // Partial byte aborted by CS, then a clean byte
    v0 = valid_cnt;
    io_cs = 1'b0;
    spi_bits(8'hB0, 5, 1'b0, 3);
    wait_clk(8);
    io_cs = 1'b1;
    wait_clk(10);
    chk("abort_count", abort_cnt, 1);
    chk("abort_no_valid", valid_cnt - v0, 0);
    io_cs = 1'b0;
    spi_bits(8'h3C, 8, 1'b0, 4);
    wait_clk(8);
    io_cs = 1'b1;
    wait_clk(8);
    chk("after_abort_valid", valid_cnt - v0, 1);
    chk("after_abort_rx_byte", last_rx_byte, 8'h3C);
    chk("after_abort_no_more_abort", abort_cnt, 1);

    // Panel reset mid-argument and mid-byte
    io_cs = 1'b0;
    spi_bits(8'h81, 8, 1'b0, 3);
    spi_bits(8'hC0, 3, 1'b0, 3);
    wait_clk(4);
    v0 = valid_cnt;
    io_reset = 1'b0;
    wait_clk(6);
    io_reset = 1'b1;
    wait_clk(6);
    chk("preset_display_on", display_on, 1'b0);
    chk("preset_invert", invert, 1'b0);
    chk("preset_contrast", contrast, 8'h7F);
    chk("preset_fb_addr", fb_addr, 10'd0);
    chk("preset_fb_wdata", fb_wdata, 8'h00);
    chk("preset_rx_byte", rx_byte, 8'h00);
    chk("preset_no_valid", valid_cnt - v0, 0);
    spi_bits(8'h10, 8, 1'b0, 3);
    wait_clk(8);
    io_cs = 1'b1;
    wait_clk(8);
    chk("preset_arg_dropped", contrast, 8'h7F);
    chk("preset_no_abort", abort_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
